// File: rtl/rx_status_sched_if.sv
// Status-queue client bus for rx_status_sched: head entry, occupancy and the pop acknowledge.
interface rx_status_sched_if #(
    parameter int LEN_W = 16,
    parameter int LVL_W = 3
);
    // Handshake: an entry is transferred on every rxclk edge where status_valid and
    // status_ack are both high; while valid is high without ack, good/len hold steady.
    // An ack while valid is low has no effect.
    logic             status_valid;
    logic             status_good;
    logic [LEN_W-1:0] status_len;
    logic [LVL_W-1:0] status_level;
    logic             status_ack;

    modport master (
        output status_valid,
        output status_good,
        output status_len,
        output status_level,
        input  status_ack
    );

    modport slave (
        input  status_valid,
        input  status_good,
        input  status_len,
        input  status_level,
        output status_ack
    );
endinterface

// File: rtl/rx_status_sched.sv
// Rx enable scheduler and per-frame status FIFO beside the rx engine.
// Define RX_STATUS_STATS_EN to build the good/bad frame counters.
module rx_status_sched #(
    parameter int DEPTH   = 4,
    parameter int RESERVE = 2,
    parameter int LEN_W   = 16,
    parameter int STAT_W  = 16,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic               rxclk,
    input  logic               reset,
    input  logic               cfg_rx_en,
    input  logic               recv_end,
    input  logic               wait_crc_check,
    input  logic               good_frame_get,
    input  logic               bad_frame_get,
    input  logic [LEN_W-1:0]   rx_byte_cnt,
    output logic               recv_enable,
    rx_status_sched_if.master  st,
    output logic [STAT_W-1:0]  drop_cnt,
    output logic [STAT_W-1:0]  good_cnt,
    output logic [STAT_W-1:0]  bad_cnt,
    output logic [1:0]         fsm_state
);

    typedef enum logic [1:0] {
        S_OFF      = 2'd0,
        S_ON       = 2'd1,
        S_THROTTLE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [LEN_W:0]     mem_q [DEPTH];
    logic [LEN_W:0]     mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [STAT_W-1:0]  drop_q, drop_d;

    logic               ev, entry_good, full, pop, push, ok;
    logic [LVL_W:0]     used;
    logic [LEN_W:0]     head;

    // FIFO datapath: a pop frees the slot in the same cycle, so a full queue
    // still accepts a push when the client acks alongside it.
    always_comb begin
        ev         = good_frame_get | bad_frame_get;
        entry_good = good_frame_get & ~bad_frame_get;
        full       = (level_q == LVL_W'(DEPTH));
        pop        = (level_q != '0) & st.status_ack;
        push       = ev & (~full | pop);

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = {entry_good, rx_byte_cnt};
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        level_d  = level_q + LVL_W'(push) - LVL_W'(pop);

        drop_d = drop_q;
        if (ev && full && !pop && !(&drop_q)) begin
            drop_d = drop_q + STAT_W'(1);
        end
    end

    // A pending FCS verdict will need a slot, so it counts as occupied.
    always_comb begin
        used = {1'b0, level_q} + (LVL_W + 1)'(wait_crc_check);
        ok   = cfg_rx_en && ((int'(used) + RESERVE) <= DEPTH);
    end

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            state_q <= S_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    // Leaving ON is only allowed at a frame boundary (recv_end high).
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_OFF: begin
                if (ok && recv_end) state_d = S_ON;
            end
            S_ON: begin
                if (recv_end && !cfg_rx_en) state_d = S_OFF;
                else if (recv_end && !ok)   state_d = S_THROTTLE;
            end
            S_THROTTLE: begin
                if (!cfg_rx_en)         state_d = S_OFF;
                else if (ok && recv_end) state_d = S_ON;
            end
            default: state_d = S_OFF;
        endcase
    end

    always_comb begin
        recv_enable     = (state_q == S_ON);
        fsm_state       = state_q;
        head            = mem_q[rd_ptr_q];
        st.status_valid = (level_q != '0);
        st.status_good  = st.status_valid & head[LEN_W];
        st.status_len   = st.status_valid ? head[LEN_W-1:0] : '0;
        st.status_level = level_q;
        drop_cnt        = drop_q;
    end

`ifdef RX_STATUS_STATS_EN
    logic [STAT_W-1:0] good_q, good_d;
    logic [STAT_W-1:0] bad_q, bad_d;

    // Only entries that made it into the FIFO are classified; drops are counted separately.
    always_comb begin
        good_d = good_q;
        bad_d  = bad_q;
        if (push && entry_good && !(&good_q)) good_d = good_q + STAT_W'(1);
        if (push && !entry_good && !(&bad_q)) bad_d = bad_q + STAT_W'(1);
    end

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            good_q <= '0;
            bad_q  <= '0;
        end else begin
            good_q <= good_d;
            bad_q  <= bad_d;
        end
    end

    assign good_cnt = good_q;
    assign bad_cnt  = bad_q;
`else
    assign good_cnt = '0;
    assign bad_cnt  = '0;
`endif

endmodule

// File: tb/tb_rx_status_sched.sv
// Bench for rx_status_sched: directed boundary checks plus random traffic against a queue model.
module tb_rx_status_sched;

    localparam int DEPTH   = 4;
    localparam int RESERVE = 2;
    localparam int LEN_W   = 16;
    localparam int STAT_W  = 16;
    localparam int LVL_W   = 3;
    localparam int SAT     = (1 << STAT_W) - 1;

    logic              rxclk = 1'b0;
    logic              reset;
    logic              cfg_rx_en, recv_end, wait_crc_check;
    logic              good_frame_get, bad_frame_get;
    logic [LEN_W-1:0]  rx_byte_cnt;
    logic              recv_enable;
    logic [STAT_W-1:0] drop_cnt, good_cnt, bad_cnt;
    logic [1:0]        fsm_state;

    rx_status_sched_if #(.LEN_W(LEN_W), .LVL_W(LVL_W)) st_if ();

    rx_status_sched #(
        .DEPTH(DEPTH), .RESERVE(RESERVE), .LEN_W(LEN_W), .STAT_W(STAT_W)
    ) dut (
        .rxclk          (rxclk),
        .reset          (reset),
        .cfg_rx_en      (cfg_rx_en),
        .recv_end       (recv_end),
        .wait_crc_check (wait_crc_check),
        .good_frame_get (good_frame_get),
        .bad_frame_get  (bad_frame_get),
        .rx_byte_cnt    (rx_byte_cnt),
        .recv_enable    (recv_enable),
        .st             (st_if),
        .drop_cnt       (drop_cnt),
        .good_cnt       (good_cnt),
        .bad_cnt        (bad_cnt),
        .fsm_state      (fsm_state)
    );

    // clock
    always #5 rxclk = ~rxclk;

    // reference model: queue of {good, len}, mode 0=off 1=receiving 2=throttled
    logic [LEN_W:0] exp_q[$];
    int m_mode, m_drop, m_good, m_bad;
    bit cmp_en = 1'b0;
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // scoreboard compare on the falling edge
    always @(negedge rxclk) begin
        if (cmp_en) begin
            chk("recv_enable", int'(recv_enable), int'(m_mode == 1));
            chk("status_valid", int'(st_if.status_valid), int'(exp_q.size() > 0));
            chk("status_level", int'(st_if.status_level), exp_q.size());
            if (exp_q.size() > 0) begin
                chk("status_good", int'(st_if.status_good), int'(exp_q[0][LEN_W]));
                chk("status_len", int'(st_if.status_len), int'(exp_q[0][LEN_W-1:0]));
            end
            chk("drop_cnt", int'(drop_cnt), m_drop);
            chk("good_cnt", int'(good_cnt), m_good);
            chk("bad_cnt", int'(bad_cnt), m_bad);
        end
    end

    task automatic model_clear();
        exp_q.delete();
        m_mode = 0;
        m_drop = 0;
        m_good = 0;
        m_bad  = 0;
    endtask

    task automatic do_reset();
        cmp_en = 1'b0;
        reset = 1'b1;
        cfg_rx_en = 0; recv_end = 0; wait_crc_check = 0;
        good_frame_get = 0; bad_frame_get = 0; rx_byte_cnt = '0;
        st_if.status_ack = 0;
        model_clear();
        repeat (2) @(posedge rxclk);
        #1 reset = 1'b0;
        cmp_en = 1'b1;
    endtask

    // driver: one clock of inputs, with the model advanced across the same edge
    task automatic cycle(input bit cfg, input bit rend, input bit wcrc, input bit g,
                         input bit b, input logic [LEN_W-1:0] len, input bit ack);
        int lvl, free, nmode;
        bit pop, ev, ok;
        cfg_rx_en = cfg; recv_end = rend; wait_crc_check = wcrc;
        good_frame_get = g; bad_frame_get = b; rx_byte_cnt = len;
        st_if.status_ack = ack;

        lvl  = exp_q.size();
        pop  = (lvl > 0) && ack;
        ev   = g || b;
        free = DEPTH - lvl - int'(wcrc);
        ok   = cfg && (free >= RESERVE);
        nmode = m_mode;
        case (m_mode)
            0: if (ok && rend) nmode = 1;
            1: begin
                if (rend && !cfg)     nmode = 0;
                else if (rend && !ok) nmode = 2;
            end
            default: begin
                if (!cfg)            nmode = 0;
                else if (ok && rend) nmode = 1;
            end
        endcase

        @(posedge rxclk);
        #1;
        if (pop) void'(exp_q.pop_front());
        if (ev) begin
            if (lvl < DEPTH || pop) begin
                exp_q.push_back({g && !b, len});
`ifdef RX_STATUS_STATS_EN
                if (g && !b) m_good = (m_good < SAT) ? m_good + 1 : SAT;
                else         m_bad  = (m_bad  < SAT) ? m_bad  + 1 : SAT;
`endif
            end else begin
                m_drop = (m_drop < SAT) ? m_drop + 1 : SAT;
            end
        end
        m_mode = nmode;
    endtask

    initial begin
        do_reset();
        chk("rst_recv_enable", int'(recv_enable), 0);
        chk("rst_valid", int'(st_if.status_valid), 0);
        chk("rst_level", int'(st_if.status_level), 0);
        chk("rst_drop", int'(drop_cnt), 0);
        chk("rst_fsm_off", int'(fsm_state), 0);

        // enable latency
        cycle(1, 1, 0, 0, 0, 0, 0);
        chk("enable_1cyc", int'(recv_enable), 1);
        chk("enable_valid0", int'(st_if.status_valid), 0);

        // single good frame of 64 bytes then ack
        cycle(1, 1, 0, 1, 0, 16'd64, 0);
        chk("push64_valid", int'(st_if.status_valid), 1);
        chk("push64_good", int'(st_if.status_good), 1);
        chk("push64_len", int'(st_if.status_len), 64);
        cycle(1, 1, 0, 0, 0, 0, 1);
        chk("pop64_level", int'(st_if.status_level), 0);

        // reserve throttling
        cycle(1, 1, 0, 1, 0, 16'd10, 0);
        cycle(1, 1, 0, 1, 0, 16'd11, 0);
        cycle(1, 1, 0, 1, 0, 16'd12, 0);
        chk("free2_still_on", int'(recv_enable), 1);
        chk("three_level", int'(st_if.status_level), 3);
        cycle(1, 1, 0, 0, 0, 0, 0);
        chk("free1_throttle", int'(recv_enable), 0);
        chk("throttle_state", int'(fsm_state), 2);
        cycle(1, 1, 0, 0, 0, 0, 1);
        chk("ack_level2", int'(st_if.status_level), 2);
        cycle(1, 1, 0, 0, 0, 0, 0);
        chk("resume_on", int'(recv_enable), 1);

        // full queue: drop, then simultaneous push/pop with bad-wins
        cycle(1, 1, 0, 1, 0, 16'd13, 0);
        cycle(1, 1, 0, 1, 0, 16'd14, 0);
        chk("full_level", int'(st_if.status_level), 4);
        cycle(1, 1, 0, 1, 1, 16'd99, 0);
        chk("drop_one", int'(drop_cnt), 1);
        chk("drop_level", int'(st_if.status_level), 4);
        chk("drop_head_len", int'(st_if.status_len), 11);
        cycle(1, 1, 0, 1, 1, 16'd77, 1);
        chk("pushpop_level", int'(st_if.status_level), 4);
        chk("pushpop_drop", int'(drop_cnt), 1);
        repeat (3) cycle(1, 1, 0, 0, 0, 0, 1);
        chk("bad_head_valid", int'(st_if.status_valid), 1);
        chk("bad_head_good", int'(st_if.status_good), 0);
        chk("bad_head_len", int'(st_if.status_len), 77);
        cycle(1, 1, 0, 0, 0, 0, 1);
        chk("drained", int'(st_if.status_level), 0);

        // no mid-frame disable
        cycle(1, 1, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0, 0);
        chk("on_before_cfg_off", int'(recv_enable), 1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0, 0, 0, 0);
            chk("midframe_hold", int'(recv_enable), 1);
        end
        cycle(0, 1, 0, 0, 0, 0, 0);
        chk("boundary_off", int'(recv_enable), 0);
        chk("boundary_fsm_off", int'(fsm_state), 0);

        // pending verdict occupies a slot
        cycle(1, 1, 0, 1, 0, 16'd5, 0);
        cycle(1, 1, 0, 1, 0, 16'd6, 0);
        cycle(1, 1, 1, 0, 0, 0, 0);
        chk("wcrc_throttle", int'(recv_enable), 0);
        cycle(1, 1, 0, 0, 0, 0, 0);
        chk("wcrc_clear_on", int'(recv_enable), 1);

        // asynchronous reset between edges
        cycle(1, 0, 0, 1, 0, 16'd8, 0);
        cmp_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("async_rst_enable", int'(recv_enable), 0);
        chk("async_rst_level", int'(st_if.status_level), 0);
        chk("async_rst_drop", int'(drop_cnt), 0);
        do_reset();

        // statistics
        for (int i = 0; i < 8; i++) begin
            cycle(1, 1, 0, i < 5, i >= 5, 16'(100 + i), 0);
            cycle(1, 1, 0, 0, 0, 0, 1);
        end
`ifdef RX_STATUS_STATS_EN
        chk("stats_good", int'(good_cnt), 5);
        chk("stats_bad", int'(bad_cnt), 3);
`else
        chk("stats_good_off", int'(good_cnt), 0);
        chk("stats_bad_off", int'(bad_cnt), 0);
`endif

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 9);
            cycle($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 4) == 0, (r <= 1) || (r == 3),
                  (r == 2) || (r == 3), 16'($urandom_range(0, 65535)),
                  $urandom_range(0, 9) < 4);
        end

        @(negedge rxclk);
        #1 cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_status_sched.md
Name: rx_status_sched

Overview:
- Controller sitting beside the rx engine state machine.
- Owns the engine's recv_enable and only changes it at frame boundaries.
- Queues per-frame result reports (good/bad flag plus byte count) in a small status FIFO drained by the client over a valid/ack handshake.
- Throttles reception so a frame's status is never lost to a full queue, and keeps saturating frame statistics.

Parameters:
- DEPTH, 4: status FIFO entries; power of 2, minimum 2.
- RESERVE, 2: minimum free entries required to keep reception enabled; 1 to DEPTH.
- LEN_W, 16: byte-count width.
- STAT_W, 16: statistics counter width.

Ports:
- rxclk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- cfg_rx_en  in  1  host enable for reception.
- recv_end  in  1  engine idle (not in DA/LT/DATA/FCS).
- wait_crc_check  in  1  frame finished FCS, verdict pending.
- good_frame_get  in  1  one-cycle good-frame pulse.
- bad_frame_get  in  1  one-cycle bad-frame pulse.
- rx_byte_cnt  in  LEN_W  frame byte count, valid in the pulse cycle.
- status_ack  in  1  client accepts the head entry.
- recv_enable  out  1  enable to the rx engine.
- status_valid  out  1  head entry available.
- status_good  out  1  head entry good flag.
- status_len  out  LEN_W  head entry byte count.
- status_level  out  log2(DEPTH)+1  FIFO occupancy.
- drop_cnt  out  STAT_W  statuses dropped because the FIFO was full.
- good_cnt  out  STAT_W  good frames (optional feature).
- bad_cnt  out  STAT_W  bad frames (optional feature).

Behaviour:
- Reset values: all outputs 0; FSM in OFF; FIFO empty.
- Event and push:
  - event = good_frame_get | bad_frame_get.
  - Pushed entry: good = good_frame_get & ~bad_frame_get (bad wins when both are asserted); len = rx_byte_cnt.
  - Push occurs in the event cycle; the entry is visible on status_valid the next cycle.
- Pop and handshake:
  - Pop on status_valid & status_ack.
  - status_good/status_len are held stable while status_valid=1 and no ack is given.
  - status_ack with status_valid=0 is ignored.
- Simultaneous push and pop:
  - Both succeed, occupancy is unchanged, including when full.
  - When full with no pop, the event is dropped, drop_cnt increments (saturating at all-ones), and FIFO contents are unchanged.
- Pointers wrap modulo DEPTH.
- status_level equals the number of valid entries, 0..DEPTH.
- free = DEPTH - status_level - wait_crc_check. The pending verdict counts as an occupied slot.
- ok = cfg_rx_en & (free >= RESERVE).
- FSM states and transitions; all evaluated on rxclk, recv_enable registered:
  - OFF (recv_enable=0): go to ON when ok & recv_end.
  - ON (recv_enable=1):
    - If recv_end & ~cfg_rx_en, go to OFF.
    - Else if recv_end & ~ok, go to THROTTLE.
    - While recv_end=0, stay in ON regardless of ok or cfg_rx_en; no mid-frame disable.
  - THROTTLE (recv_enable=0):
    - If ~cfg_rx_en, go to OFF.
    - Else if ok & recv_end, go to ON.
- Latency: recv_enable follows the qualifying condition by exactly 1 cycle.
- Async reset mid-frame: immediately returns to OFF, empties the FIFO and clears counters.

Optional Feature:
- Macro RX_STATUS_STATS_EN.
- Defined:
  - good_cnt increments on each pushed good entry; bad_cnt on each pushed bad entry.
  - Dropped events are counted only in drop_cnt.
  - Both counters saturate at all-ones.
- Undefined: good_cnt and bad_cnt are constant 0 and no counter logic is built. drop_cnt is always present.

Test Plan:
- Reset, then cfg_rx_en=1, recv_end=1 -> recv_enable=1 one cycle later; status_valid=0; status_level=0.
- Good pulse with rx_byte_cnt=64, client acks the following cycle -> status_valid=1, status_good=1, status_len=64; after ack, status_level=0.
- DEPTH=4, RESERVE=2, no acks, three good pulses, each delivered with recv_end=1 -> after the second push free=2, recv_enable stays 1; after the third push free=1, recv_enable=0 (THROTTLE). One ack -> recv_enable=1 again.
- Full FIFO, good and bad pulses asserted in the same cycle with no ack -> drop_cnt=1, level stays 4. Repeat with status_ack=1 in the same cycle -> pushed entry good=0, level 4, drop_cnt unchanged.
- cfg_rx_en dropped while recv_end=0 -> recv_enable stays 1 until recv_end=1, then 0 the next cycle, FSM in OFF.
- With RX_STATUS_STATS_EN defined: 5 good and 3 bad pulses, all acked -> good_cnt=5, bad_cnt=3. Undefined -> both 0.
